// File: rtl/crono_pkg.sv
// Shared types and limits for the stopwatch controller; LAP exists only when CRONO_LAP_EN is defined.
package crono_pkg;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HRS_MAX = 23;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned HRS_W   = 5;

`ifdef CRONO_LAP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;
`endif

  // Time advances in RUN and, when present, LAP.
  function automatic logic is_live(input state_t s);
`ifdef CRONO_LAP_EN
    return (s == ST_RUN) || (s == ST_LAP);
`else
    return (s == ST_RUN);
`endif
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter stage; wrap is en-qualified so stages chain directly.
module mod_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] value_q, value_d;

  assign wrap    = en && (value_q == MAX_V);
  assign value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
  assign value   = value_q;

  always_ff @(posedge clk) begin
    if (reset || clr) value_q <= '0;
    else if (en)      value_q <= value_d;
  end

endmodule

// File: rtl/cronometru_ctrl.sv
// Stopwatch run/pause/lap sequencer with 1 s prescaler driving a sec/min/hrs counter chain.
// Build macro CRONO_LAP_EN enables the LAP state and the frozen-display snapshot.
module cronometru_ctrl
  import crono_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_lap,
  output logic [SEC_W-1:0] disp_sec,
  output logic [MIN_W-1:0] disp_min,
  output logic [HRS_W-1:0] disp_hrs,
  output logic             running,
  output logic             lap_active,
  output logic             rollover
);

  localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             rollover_q;
  logic             live_en, tick, clr;
  logic             sec_wrap, min_wrap, hrs_wrap;
  logic [SEC_W-1:0] live_sec;
  logic [MIN_W-1:0] live_min;
  logic [HRS_W-1:0] live_hrs;

  assign live_en = is_live(state_q);
  assign tick    = live_en && (presc_q == PRESC_LAST);

`ifdef CRONO_LAP_EN
  logic             snap_cap;
  logic [SEC_W-1:0] snap_sec_q;
  logic [MIN_W-1:0] snap_min_q;
  logic [HRS_W-1:0] snap_hrs_q;
`endif

  // btn_start is tested first everywhere so it wins over btn_lap.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
`ifdef CRONO_LAP_EN
    snap_cap = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (btn_start) state_d = ST_RUN;
      ST_RUN: begin
        if (btn_start) state_d = ST_PAUSE;
`ifdef CRONO_LAP_EN
        else if (btn_lap) begin
          state_d  = ST_LAP;
          snap_cap = 1'b1;
        end
`endif
      end
      ST_PAUSE: begin
        if (btn_start) state_d = ST_RUN;
        else if (btn_lap) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end
      end
`ifdef CRONO_LAP_EN
      ST_LAP: begin
        if (btn_start)    state_d = ST_PAUSE;
        else if (btn_lap) state_d = ST_RUN;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // PAUSE holds the partial second so a resume continues mid-second.
  always_comb begin
    presc_d = presc_q;
    if (live_en)                           presc_d = tick ? '0 : presc_q + 1'b1;
    else if (clr || state_q == ST_IDLE)    presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      rollover_q <= hrs_wrap;
    end
  end

  mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk(clk), .reset(reset), .clr(clr), .en(tick), .value(live_sec), .wrap(sec_wrap));
  mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk(clk), .reset(reset), .clr(clr), .en(sec_wrap), .value(live_min), .wrap(min_wrap));
  mod_counter #(.MAX(HRS_MAX), .W(HRS_W)) u_hrs (
    .clk(clk), .reset(reset), .clr(clr), .en(min_wrap), .value(live_hrs), .wrap(hrs_wrap));

  assign running  = live_en;
  assign rollover = rollover_q;

`ifdef CRONO_LAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_sec_q <= '0;
      snap_min_q <= '0;
      snap_hrs_q <= '0;
    end else if (snap_cap) begin
      snap_sec_q <= live_sec;
      snap_min_q <= live_min;
      snap_hrs_q <= live_hrs;
    end
  end

  assign lap_active = (state_q == ST_LAP);
  assign disp_sec   = lap_active ? snap_sec_q : live_sec;
  assign disp_min   = lap_active ? snap_min_q : live_min;
  assign disp_hrs   = lap_active ? snap_hrs_q : live_hrs;
`else
  assign lap_active = 1'b0;
  assign disp_sec   = live_sec;
  assign disp_min   = live_min;
  assign disp_hrs   = live_hrs;
`endif

endmodule

// File: tb/tb_cronometru_ctrl.sv
// Bench for cronometru_ctrl: directed scenarios plus random button traffic against a seconds-based model.
module tb_cronometru_ctrl;

  localparam int unsigned T   = 4;
  localparam int          DAY = 86400;
`ifdef CRONO_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0, btn_start = 1'b0, btn_lap = 1'b0;
  logic [5:0] disp_sec, disp_min;
  logic [4:0] disp_hrs;
  logic       running, lap_active, rollover;

  int n_chk  = 0;
  int n_pass = 0;

  cronometru_ctrl #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap),
    .disp_sec(disp_sec), .disp_min(disp_min), .disp_hrs(disp_hrs),
    .running(running), .lap_active(lap_active), .rollover(rollover));

  always #5 clk = ~clk;

  // Reference model: elapsed time kept as plain seconds since 00:00:00.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_e;
  mstate_e m_st    = M_IDLE;
  int      m_presc = 0;
  int      m_t     = 0;
  int      m_snap  = 0;
  bit      m_roll  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void model_update(input bit s, input bit l, input bit r);
    bit live, tick;
    int t0;
    if (r) begin
      m_st = M_IDLE; m_presc = 0; m_t = 0; m_snap = 0; m_roll = 1'b0;
      return;
    end
    t0     = m_t;
    live   = (m_st == M_RUN) || (m_st == M_LAP);
    tick   = live && (m_presc == int'(T) - 1);
    m_roll = tick && (m_t == DAY - 1);
    if (tick) m_t = (m_t + 1) % DAY;
    if (live) m_presc = tick ? 0 : m_presc + 1;
    if (s) begin
      case (m_st)
        M_IDLE:       m_st = M_RUN;
        M_RUN, M_LAP: m_st = M_PAUSE;
        M_PAUSE:      m_st = M_RUN;
        default:      m_st = M_IDLE;
      endcase
    end else if (l) begin
      case (m_st)
        M_RUN:   if (LAP_EN) begin m_st = M_LAP; m_snap = t0; end
        M_PAUSE: begin m_st = M_IDLE; m_t = 0; m_presc = 0; end
        M_LAP:   m_st = M_RUN;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] model_vec();
    int  sh;
    logic run_e, lap_e;
    sh    = (m_st == M_LAP) ? m_snap : m_t;
    run_e = (m_st == M_RUN) || (m_st == M_LAP);
    lap_e = (m_st == M_LAP);
    return 32'({5'(sh / 3600), 6'((sh / 60) % 60), 6'(sh % 60), run_e, lap_e, m_roll});
  endfunction

  function automatic logic [31:0] dut_vec();
    return 32'({disp_hrs, disp_min, disp_sec, running, lap_active, rollover});
  endfunction

  task automatic step(input bit s, input bit l, input bit r);
    btn_start = s; btn_lap = l; reset = r;
    @(posedge clk);
    model_update(s, l, r);
    @(negedge clk);
    btn_start = 1'b0; btn_lap = 1'b0; reset = 1'b0;
    check_eq("cycle_model", dut_vec(), model_vec());
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit seen;
    int rolls;

    // Reset, then idle with stray lap presses.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check_eq("reset_zero", dut_vec(), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    check_eq("idle_zero", dut_vec(), 32'd0);

    // First second and the minute carry.
    step(1'b1, 1'b0, 1'b0);
    run(3);
    check_eq("pre_first_sec", 32'(disp_sec), 32'd0);
    run(1);
    check_eq("first_sec", 32'(disp_sec), 32'd1);
    run(235);
    check_eq("sec_59", 32'({disp_min, disp_sec}), 32'({6'd0, 6'd59}));
    run(1);
    check_eq("min_carry", 32'({disp_min, disp_sec}), 32'({6'd1, 6'd0}));
    run(4);
    check_eq("t_00_01_01", 32'({disp_hrs, disp_min, disp_sec}), 32'({5'd0, 6'd1, 6'd1}));
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_eq("pause_clear", dut_vec(), 32'd0);

    // Partial second survives a pause.
    step(1'b1, 1'b0, 1'b0);
    run(2);
    step(1'b1, 1'b0, 1'b0);
    run(20);
    check_eq("paused_hold", 32'({running, disp_sec}), 32'({1'b0, 6'd0}));
    step(1'b1, 1'b0, 1'b0);
    check_eq("resume_edge", 32'({running, disp_sec}), 32'({1'b1, 6'd0}));
    run(1);
    check_eq("resume_partial", 32'(disp_sec), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_eq("clear_again", dut_vec(), 32'd0);

    // Lap freeze at 00:00:05 for 8 s.
    step(1'b1, 1'b0, 1'b0);
    run(20);
    check_eq("pre_lap", 32'(disp_sec), 32'd5);
    step(1'b0, 1'b1, 1'b0);
    check_eq("lap_enter", 32'(lap_active), 32'(LAP_EN));
    run(32);
    check_eq("lap_frozen", 32'(disp_sec), LAP_EN ? 32'd5 : 32'd13);
    check_eq("lap_running", 32'(running), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check_eq("lap_exit_live", 32'({lap_active, disp_sec}), 32'({1'b0, 6'd13}));

    // Preload 23:59:50 while paused, then run through midnight.
    step(1'b1, 1'b0, 1'b0);
    force dut.u_sec.value_q = 6'd50;
    force dut.u_min.value_q = 6'd59;
    force dut.u_hrs.value_q = 5'd23;
    @(posedge clk);
    @(negedge clk);
    release dut.u_sec.value_q;
    release dut.u_min.value_q;
    release dut.u_hrs.value_q;
    m_t = 23 * 3600 + 59 * 60 + 50;
    check_eq("preload", 32'({disp_hrs, disp_min, disp_sec}), 32'({5'd23, 6'd59, 6'd50}));
    step(1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (rollover) begin
        seen = 1'b1;
        check_eq("roll_disp", 32'({disp_hrs, disp_min, disp_sec}), 32'd0);
      end
    end
    check_eq("roll_seen", 32'(seen), 32'd1);
    rolls = 0;
    repeat (8) begin
      step(1'b0, 1'b0, 1'b0);
      rolls += int'(rollover);
    end
    check_eq("roll_single", 32'(rolls), 32'd0);

    // Both buttons from RUN pause; reset mid-run clears everything.
    step(1'b1, 1'b1, 1'b0);
    check_eq("both_btn_pause", 32'({running, lap_active}), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run(28);
    check_eq("pre_reset_7", 32'(disp_sec), 32'd7);
    step(1'b1, 1'b1, 1'b1);
    check_eq("reset_mid_run", dut_vec(), 32'd0);

    // Random button traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 399) == 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cronometru_ctrl.md
# cronometru_ctrl

Stopwatch controller that sequences a chain of cascaded modulo counters (seconds mod 60, minutes mod 60, hours mod 24) from two push-button pulses. It holds the run/pause/lap state machine and a one-second prescaler, and gates counter enables. It drives the display path with either live or frozen (lap) time. It sits between the button synchronisers and the 7-segment/BCD display logic.

## Interface
- TICKS_PER_SEC, default 100000000: clock cycles per counted second (must be ≥ 2).
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- btn_start  input  1  single-cycle pulse, already synchronised and debounced; start/stop toggle.
- btn_lap  input  1  single-cycle pulse, already synchronised and debounced; lap when running, clear when paused.
- disp_sec  output  6  displayed seconds, 0..59.
- disp_min  output  6  displayed minutes, 0..59.
- disp_hrs  output  5  displayed hours, 0..23.
- running  output  1  high in RUN and LAP.
- lap_active  output  1  high in LAP (display frozen).
- rollover  output  1  one-cycle pulse on 23:59:59 -> 00:00:00.

## Operation
- States: IDLE, RUN, PAUSE, LAP.
- IDLE + btn_start -> RUN. IDLE + btn_lap -> no effect.
- RUN + btn_start -> PAUSE. RUN + btn_lap -> LAP, snapshot of live time captured on the same edge.
- PAUSE + btn_start -> RUN. PAUSE + btn_lap -> IDLE, live counters and prescaler cleared to 0 on that edge.
- LAP + btn_lap -> RUN, display returns to live. LAP + btn_start -> PAUSE, display returns to live.
- Both buttons in the same cycle: btn_start wins, btn_lap ignored.
- Prescaler counts 0..TICKS_PER_SEC-1 only in RUN/LAP. It holds its value in PAUSE and is not reset, so a paused partial second resumes. It is cleared in IDLE.
- Internal tick = (prescaler == TICKS_PER_SEC-1) and state in {RUN, LAP}.
- On tick: sec+1. When sec is 59, sec wraps to 0 and min+1. When min is 59, min wraps to 0 and hrs+1. When hrs is 23, hrs wraps to 0 and rollover is asserted.
- Display outputs show the snapshot in LAP and the live counters otherwise. Live counters keep counting during LAP.

## Timing
- Reset values: all disp_* = 0, running = 0, lap_active = 0, rollover = 0, state IDLE, prescaler 0, snapshot 0.
- All outputs are registered or decoded from registers. There is no combinational path from buttons to outputs.
- State changes on the edge that samples a button pulse. running and lap_active reflect the new state in the following cycle.
- After entering RUN from IDLE, the first sec increment is visible TICKS_PER_SEC cycles after the btn_start edge.
- rollover is high for exactly the cycle in which the display shows 00:00:00 following 23:59:59 (live display).
- A reset asserted mid-run overrides every button and tick in that cycle.

## Configuration
- CRONO_LAP_EN defined: LAP state, snapshot registers and lap_active behave as above.
- CRONO_LAP_EN undefined: btn_lap in RUN is ignored and the LAP state is not encoded. Snapshot registers are absent, lap_active is tied to 0, and displays are always live. btn_lap still clears from PAUSE.

## Structure
- Package crono_pkg holds:
  - state encoding constants for IDLE, RUN, PAUSE and LAP;
  - SEC_MAX = 59, MIN_MAX = 59, HRS_MAX = 23;
  - widths 6/6/5.
- One sub-module, mod_counter: parameters MAX and W; ports clk, reset, clr, en, value, wrap. It is instantiated three times with wrap chained into the next stage's en, qualified by the upstream enable.

## Test plan
- Reset, then idle for 10 cycles with TICKS_PER_SEC = 4 -> all outputs 0, running = 0.
- btn_start at cycle 0, run 4×61 cycles -> disp_sec 0->1 at cycle 4, 59->0 with disp_min 0->1 at cycle 240, then 00:01:01.
- Run for 3 cycles, btn_start (pause), hold 20 cycles, btn_start again -> sec becomes 1 exactly 1 cycle after resume. PAUSE + btn_lap -> 00:00:00, IDLE.
- At 00:00:05, press btn_lap -> display frozen at 5 and lap_active = 1 for 8 s. Press btn_lap again -> display jumps to live 00:00:13. Without CRONO_LAP_EN, display stays live throughout.
- Run 86400×4 cycles -> rollover pulses once, display reads 00:00:00 that cycle.
- Both buttons in the same cycle from RUN -> PAUSE. Reset at 00:00:07 -> all outputs 0 on the next cycle.
